comp_share_arb: RTL and testbench
=================================

Name: comp_share_arb

Overview:
- Shares one 8-bit four-output magnitude comparator (gt, eq, ae, lt) among NREQ requesters.
- Each requester hands in an operand pair over a valid/ready handshake.
- A round-robin arbiter grants one pair per cycle into the comparator.
- The registered result is returned on a single response channel, tagged with the requester ID. It sits between the requester engines and the shared compare datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width in bits.
- TOL, 2, approximate-equal tolerance: ae=1 when |A-B| <= TOL.
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  IDW  requester index of the result.
- rsp_gt  out  1  A > B.
- rsp_eq  out  1  A == B.
- rsp_ae  out  1  |A-B| <= TOL.
- rsp_lt  out  1  A < B.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rsp_valid=0; rsp_id=0; rsp_gt/eq/ae/lt=0.
  - Round-robin pointer = 0, so requester 0 has top priority.
  - req_ready is 0 while in reset.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Arbitration is combinational each cycle when slot_free=1:
  - Scan requesters starting at ptr and wrapping modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - When slot_free=0, all req_ready=0.
- Transfer: a request transfers when req_valid[i] && req_ready[i]. On that edge:
  - Compare req_a[i] with req_b[i], unsigned.
  - Register gt, eq, ae, lt and rsp_id=i; set rsp_valid=1.
  - Update ptr to (i+1) mod NREQ.
- Latency: 1 cycle from accept to rsp_valid. Throughput: 1 result per cycle while rsp_ready=1.
- Response hold: when rsp_valid=1 && rsp_ready=0, all rsp_* outputs are held stable and no new grant is issued (backpressure).
- Release: when rsp_ready=1 with no new transfer on that edge, rsp_valid drops to 0 and the data fields hold their last values.
- Simultaneous accept and drain on the same edge: the new result replaces the old one; rsp_valid stays 1.
- Pointer advance: ptr changes only on a transfer. Idle cycles do not advance it.
- Flag rules:
  - Exactly one of gt/eq/lt is 1 for every valid result.
  - eq=1 implies ae=1.
  - ae is computed from the W-bit absolute difference, with no overflow: use the larger operand minus the smaller.
- Requester rules:
  - A requester must hold req_a/req_b stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before it is accepted is legal; the pair is simply never compared.
- Reset mid-operation: any in-flight result is discarded (rsp_valid=0) and ptr returns to 0.
- Parameter check: TOL >= 2**W is legal and makes ae always 1.

Optional Feature:
- Macro: COMP_SHARE_STATS_EN.
- When defined, the block adds these ports:
  - stat_clr  in  1  synchronous clear of all counters.
  - stat_gt, stat_eq, stat_lt  out  16 each  count of accepted results per outcome.
  - stat_ae  out  16  count of accepted results with ae=1.
- Counters increment on each transfer edge, saturate at 16'hFFFF, and reset to 0 on rst_n=0.
- If stat_clr and a transfer occur on the same edge, the clear wins and counters read 0 on the next cycle.
- When not defined: none of these ports exist and there is no counter logic.

Test Plan:
- Single requester: req0 sends A=5,B=1 with rsp_ready=1 -> one cycle later rsp_valid=1, id=0, {gt,eq,lt}=100, ae=0.
- Tolerance boundary: A=150,B=148 -> {gt,eq,lt}=100, ae=1. A=140,B=150 -> 001, ae=0. A=50,B=50 -> 010, ae=1. A=148,B=150 -> 001, ae=1.
- Round-robin: all 4 requesters valid continuously from reset with rsp_ready=1 -> grant order 0,1,2,3,0,1, one result per cycle, ids matching.
- Backpressure: rsp_ready=0 for 3 cycles with a result pending -> rsp_* held stable, req_ready=0. Release -> the next grant goes to the requester after the last one granted.
- Mid-stream reset: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately. After release, with req1 and req0 both valid, req0 is granted first.
- With COMP_SHARE_STATS_EN: 3 gt results, 2 eq, 1 lt -> stat_gt=3, stat_eq=2, stat_lt=1, stat_ae=2 (eq cases only). stat_clr -> all counters 0.

Source files
------------

// File: rtl/comp_share_arb.sv
// comp_share_arb
//   Shares one unsigned magnitude comparator (gt, eq, ae, lt) among NREQ
//   requesters. A round-robin arbiter grants at most one operand pair per
//   cycle. The comparison is registered and returned on a single response
//   channel, tagged with the requester index.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          packed operands, requester i uses [i*W +: W]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester that produced the result
//   rsp_gt/eq/ae/lt       A>B, A==B, |A-B|<=TOL, A<B
//
// Optional build macro: COMP_SHARE_STATS_EN
//   adds stat_clr (synchronous clear) and saturating 16-bit outcome counters
//   stat_gt, stat_eq, stat_lt, stat_ae.

module comp_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int TOL  = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gt,
    output logic              rsp_eq,
    output logic              rsp_ae,
    output logic              rsp_lt
`ifdef COMP_SHARE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_gt,
    output logic [15:0]       stat_eq,
    output logic [15:0]       stat_lt,
    output logic [15:0]       stat_ae
`endif
);

    localparam int unsigned NREQ_U = NREQ;

    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic           gt_q, gt_d, eq_q, eq_d, ae_q, ae_d, lt_q, lt_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  scan_id;
    logic            found;
    logic            slot_free;
    logic [W-1:0]    a_sel, b_sel, diff;

    assign slot_free = !valid_q || rsp_ready;

    // Round-robin scan starting at ptr; ready is held low throughout reset.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        scan_id  = '0;
        found    = 1'b0;
        if (rst_n && slot_free) begin
            for (int unsigned k = 0; k < NREQ_U; k++) begin
                scan_id = IDW'((32'(ptr_q) + k) % NREQ_U);
                if (!found && req_valid[scan_id]) begin
                    found          = 1'b1;
                    grant[scan_id] = 1'b1;
                    grant_id       = scan_id;
                end
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    // Larger minus smaller keeps the difference within W bits; the
    // tolerance compare is widened so TOL >= 2**W simply forces ae=1.
    assign diff = (a_sel > b_sel) ? (a_sel - b_sel) : (b_sel - a_sel);

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        ae_d    = ae_q;
        lt_d    = lt_q;
        ptr_d   = ptr_q;
        if (found) begin
            valid_d = 1'b1;
            id_d    = grant_id;
            gt_d    = a_sel > b_sel;
            eq_d    = a_sel == b_sel;
            lt_d    = a_sel < b_sel;
            ae_d    = 64'(diff) <= 64'(TOL);
            ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end else if (rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            ae_q    <= 1'b0;
            lt_q    <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            ae_q    <= ae_d;
            lt_q    <= lt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_gt    = gt_q;
    assign rsp_eq    = eq_q;
    assign rsp_ae    = ae_q;
    assign rsp_lt    = lt_q;

`ifdef COMP_SHARE_STATS_EN
    logic [15:0] cnt_gt_q, cnt_gt_d, cnt_eq_q, cnt_eq_d;
    logic [15:0] cnt_lt_q, cnt_lt_d, cnt_ae_q, cnt_ae_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Clear takes priority over a same-edge transfer.
    always_comb begin
        cnt_gt_d = cnt_gt_q;
        cnt_eq_d = cnt_eq_q;
        cnt_lt_d = cnt_lt_q;
        cnt_ae_d = cnt_ae_q;
        if (stat_clr) begin
            cnt_gt_d = '0;
            cnt_eq_d = '0;
            cnt_lt_d = '0;
            cnt_ae_d = '0;
        end else if (found) begin
            if (gt_d) cnt_gt_d = sat_inc(cnt_gt_q);
            if (eq_d) cnt_eq_d = sat_inc(cnt_eq_q);
            if (lt_d) cnt_lt_d = sat_inc(cnt_lt_q);
            if (ae_d) cnt_ae_d = sat_inc(cnt_ae_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_gt_q <= '0;
            cnt_eq_q <= '0;
            cnt_lt_q <= '0;
            cnt_ae_q <= '0;
        end else begin
            cnt_gt_q <= cnt_gt_d;
            cnt_eq_q <= cnt_eq_d;
            cnt_lt_q <= cnt_lt_d;
            cnt_ae_q <= cnt_ae_d;
        end
    end

    assign stat_gt = cnt_gt_q;
    assign stat_eq = cnt_eq_q;
    assign stat_lt = cnt_lt_q;
    assign stat_ae = cnt_ae_q;
`endif

endmodule

// File: tb/tb_comp_share_arb.sv
module tb_comp_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TOL  = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_gt, rsp_eq, rsp_ae, rsp_lt;
`ifdef COMP_SHARE_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_gt, stat_eq, stat_lt, stat_ae;
`endif

    comp_share_arb #(.NREQ(NREQ), .W(W), .TOL(TOL), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_ae(rsp_ae), .rsp_lt(rsp_lt)
`ifdef COMP_SHARE_STATS_EN
        , .stat_clr(stat_clr), .stat_gt(stat_gt), .stat_eq(stat_eq),
        .stat_lt(stat_lt), .stat_ae(stat_ae)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: the pending response and the priority pointer.
    bit         m_valid;
    int         m_id;
    logic [3:0] m_flags;     // {gt, eq, ae, lt}
    int         m_ptr;
    int         g_last;

    typedef struct {
        int         a;
        int         b;
        logic [3:0] flags;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_flags(input int a, input int b);
        int d;
        d = (a > b) ? a - b : b - a;
        return {a > b, a == b, d <= TOL, a < b};
    endfunction

    function automatic int m_grant(input logic [NREQ-1:0] v, input bit rr);
        if (m_valid && !rr) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_valid = 0; m_id = 0; m_flags = '0; m_ptr = 0; g_last = -1;
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                         input logic [NREQ*W-1:0] b, input bit rr);
        int g;
        logic [NREQ-1:0] exp_ready;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_flags", 32'({rsp_gt, rsp_eq, rsp_ae, rsp_lt}), 32'(m_flags));
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        g = m_grant(v, rr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1;
            m_id    = g;
            m_flags = ref_flags(int'(a[g*W +: W]), int'(b[g*W +: W]));
            m_ptr   = (g + 1) % NREQ;
        end else if (rr) begin
            m_valid = 0;
        end
        g_last = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    logic [NREQ-1:0]   v;
    logic [NREQ*W-1:0] ra, rb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{5,   1,   4'b1000};
        tbl[1]  = '{150, 148, 4'b1010};
        tbl[2]  = '{140, 150, 4'b0001};
        tbl[3]  = '{50,  50,  4'b0110};
        tbl[4]  = '{148, 150, 4'b0011};
        tbl[5]  = '{0,   255, 4'b0001};
        tbl[6]  = '{255, 0,   4'b1000};
        tbl[7]  = '{255, 253, 4'b1010};
        tbl[8]  = '{0,   3,   4'b0001};
        tbl[9]  = '{3,   0,   4'b1000};
        tbl[10] = '{1,   0,   4'b1010};
        tbl[11] = '{255, 255, 4'b0110};

        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
`ifdef COMP_SHARE_STATS_EN
        stat_clr = 1'b0;
`endif
        m_reset();
        @(negedge clk);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_id", 32'(rsp_id), 32'd0);
        chk("reset_flags", 32'({rsp_gt, rsp_eq, rsp_ae, rsp_lt}), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Vector table, each pair on a single requester.
        for (int i = 0; i < 12; i++) begin
            int r;
            r = i % NREQ;
            v = '0; v[r] = 1'b1;
            ra = $urandom; rb = $urandom;
            ra[r*W +: W] = W'(tbl[i].a);
            rb[r*W +: W] = W'(tbl[i].b);
            cycle(v, ra, rb, 1'b1);
            chk("tbl_valid", 32'(rsp_valid), 32'd1);
            chk("tbl_id", 32'(rsp_id), 32'(r));
            chk("tbl_flags", 32'({rsp_gt, rsp_eq, rsp_ae, rsp_lt}), 32'(tbl[i].flags));
        end
        cycle('0, '0, '0, 1'b1);
        chk("release_valid", 32'(rsp_valid), 32'd0);

        // Round-robin from reset with everyone valid.
        do_reset();
        ra = {8'd40, 8'd30, 8'd20, 8'd10};
        rb = {8'd40, 8'd31, 8'd19, 8'd10};
        for (int k = 0; k < 6; k++) begin
            cycle('1, ra, rb, 1'b1);
            chk("rr_id", 32'(rsp_id), 32'(k % NREQ));
        end

        // Backpressure: result held, no grants, then resume at next requester.
        for (int k = 0; k < 3; k++) begin
            cycle('1, ra, rb, 1'b0);
            chk("bp_hold_id", 32'(rsp_id), 32'd1);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        end
        cycle('1, ra, rb, 1'b1);
        chk("bp_next_id", 32'(rsp_id), 32'd2);

        // Reset while a result is pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b0011, ra, rb, 1'b1);
        chk("midrst_first_id", 32'(rsp_id), 32'd0);

        // Randomized traffic; pending pairs are held until granted or dropped.
        v = '0; ra = '0; rb = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(v[i] && g_last != i && $urandom_range(0, 9) != 0)) begin
                    int t;
                    v[i] = 1'($urandom_range(0, 1));
                    ra[i*W +: W] = W'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        t = int'(ra[i*W +: W]) + int'($urandom_range(0, 8)) - 4;
                        if (t < 0) t = 0;
                        if (t > 255) t = 255;
                        rb[i*W +: W] = W'(t);
                    end else begin
                        rb[i*W +: W] = W'($urandom);
                    end
                end
            end
            cycle(v, ra, rb, $urandom_range(0, 3) != 0);
        end

`ifdef COMP_SHARE_STATS_EN
        do_reset();
        begin
            int pa[6];
            int pb[6];
            pa = '{9, 200, 7, 5, 0, 1};
            pb = '{1, 3,   0, 5, 0, 100};
            for (int i = 0; i < 6; i++) begin
                ra = '0; rb = '0;
                ra[W-1:0] = W'(pa[i]);
                rb[W-1:0] = W'(pb[i]);
                cycle(4'b0001, ra, rb, 1'b1);
            end
        end
        chk("stat_gt", 32'(stat_gt), 32'd3);
        chk("stat_eq", 32'(stat_eq), 32'd2);
        chk("stat_lt", 32'(stat_lt), 32'd1);
        chk("stat_ae", 32'(stat_ae), 32'd2);
        stat_clr = 1'b1;
        cycle(4'b0001, {24'd0, 8'd9}, {24'd0, 8'd1}, 1'b1);
        stat_clr = 1'b0;
        chk("stat_clr_gt", 32'(stat_gt), 32'd0);
        chk("stat_clr_eq", 32'(stat_eq), 32'd0);
        chk("stat_clr_lt", 32'(stat_lt), 32'd0);
        chk("stat_clr_ae", 32'(stat_ae), 32'd0);
`endif

        cycle('0, '0, '0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
